// File: rtl/regbank_wb_arbiter.sv
// Writeback arbiter for the 32x32 register bank. It merges the memory pipe (strict priority)
// with an in-order ALU queue and reports pending writes so issue logic can detect RAW hazards.
module regbank_wb_arbiter #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int FIFO_DEPTH  = 4,
  parameter int ZERO_REG_WE = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [ADDR_W-1:0]             alu_dr,
  input  logic [DATA_W-1:0]             alu_data,
  input  logic                          mem_valid,
  input  logic [ADDR_W-1:0]             mem_dr,
  input  logic [DATA_W-1:0]             mem_data,
  output logic                          wr_en,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [DATA_W-1:0]             wr_data,
  input  logic [ADDR_W-1:0]             query_addr,
  output logic                          busy_hit,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]     entDr   [FIFO_DEPTH];
  logic [DATA_W-1:0]     entData [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] entValid, entLive, validNxt, liveNxt;
  logic [PTR_W-1:0]      rdPtr, wrPtr;
  logic [CNT_W-1:0]      count, countNxt;

  logic              aluAcc, fifoEmpty, push, pop;
  logic              outLoad, outEnNxt;
  logic [ADDR_W-1:0] outAddrNxt;
  logic [DATA_W-1:0] outDataNxt;
  logic              hit;

  function automatic logic isSuppressed(input logic [ADDR_W-1:0] a);
    return (ZERO_REG_WE == 0) && (a == '0);
  endfunction

  assign alu_ready  = rst_n && (count != CNT_W'(FIFO_DEPTH));
  assign fifo_count = count;

  always_comb begin
    aluAcc    = alu_valid && alu_ready;
    fifoEmpty = (count == '0);
    push      = aluAcc && (mem_valid || !fifoEmpty);
    pop       = !mem_valid && !fifoEmpty;

    outLoad    = 1'b1;
    outEnNxt   = 1'b0;
    outAddrNxt = wr_addr;
    outDataNxt = wr_data;
    if (mem_valid) begin
      outAddrNxt = mem_dr;
      outDataNxt = mem_data;
      outEnNxt   = !isSuppressed(mem_dr);
    end else if (!fifoEmpty) begin
      outAddrNxt = entDr[rdPtr];
      outDataNxt = entData[rdPtr];
      outEnNxt   = entLive[rdPtr] && !isSuppressed(entDr[rdPtr]);
    end else if (aluAcc) begin
      outAddrNxt = alu_dr;
      outDataNxt = alu_data;
      outEnNxt   = !isSuppressed(alu_dr);
    end else begin
      outLoad = 1'b0;
    end

    // Queued entries are older than an accepted mem write to the same register, so they die;
    // a push in this same cycle is younger and is marked live after the kill.
    validNxt = entValid;
    liveNxt  = entLive;
    if (mem_valid) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (entValid[i] && (entDr[i] == mem_dr)) liveNxt[i] = 1'b0;
      end
    end
    if (pop) begin
      validNxt[rdPtr] = 1'b0;
      liveNxt[rdPtr]  = 1'b0;
    end
    if (push) begin
      validNxt[wrPtr] = 1'b1;
      liveNxt[wrPtr]  = 1'b1;
    end

    unique case ({push, pop})
      2'b10:   countNxt = count + CNT_W'(1);
      2'b01:   countNxt = count - CNT_W'(1);
      default: countNxt = count;
    endcase
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entValid[i] && entLive[i] && (entDr[i] == query_addr)) hit = 1'b1;
    end
    if (wr_en && (wr_addr == query_addr))     hit = 1'b1;
    if (mem_valid && (mem_dr == query_addr))  hit = 1'b1;
    if (aluAcc && (alu_dr == query_addr))     hit = 1'b1;
    if (isSuppressed(query_addr))             hit = 1'b0;
    busy_hit = rst_n && hit;
  end

  // Queue storage: payload only, qualified by entValid so it needs no reset
  always_ff @(posedge clk) begin
    if (push) begin
      entDr[wrPtr]   <= alu_dr;
      entData[wrPtr] <= alu_data;
    end
  end

  // Queue control and registered output stage to the register bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entValid <= '0;
      entLive  <= '0;
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      entValid <= validNxt;
      entLive  <= liveNxt;
      count    <= countNxt;
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      wr_en <= outEnNxt;
      if (outLoad) begin
        wr_addr <= outAddrNxt;
        wr_data <= outDataNxt;
      end
    end
  end

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Directed bench for regbank_wb_arbiter: two instances differ only in ZERO_REG_WE.
module tb_regbank_wb_arbiter;

  logic        clk, rst_n;
  logic        alu_valid, mem_valid;
  logic [4:0]  alu_dr, mem_dr, query_addr;
  logic [31:0] alu_data, mem_data;

  logic        alu_ready0, wr_en0, busy_hit0;
  logic [4:0]  wr_addr0;
  logic [31:0] wr_data0;
  logic [2:0]  fifo_count0;
  logic        alu_ready1, wr_en1, busy_hit1;
  logic [4:0]  wr_addr1;
  logic [31:0] wr_data1;
  logic [2:0]  fifo_count1;

  int vectors = 0;
  int miscompares = 0;

  regbank_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(4), .ZERO_REG_WE(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready0), .alu_dr(alu_dr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_dr(mem_dr), .mem_data(mem_data),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .query_addr(query_addr), .busy_hit(busy_hit0), .fifo_count(fifo_count0)
  );

  regbank_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(4), .ZERO_REG_WE(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready1), .alu_dr(alu_dr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_dr(mem_dr), .mem_data(mem_data),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .query_addr(query_addr), .busy_hit(busy_hit1), .fifo_count(fifo_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_dr = '0; alu_data = '0;
    mem_valid = 1'b0; mem_dr = '0; mem_data = '0;
  endtask

  initial begin
    idle();
    query_addr = 5'd3;
    rst_n = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_wr_en", wr_en0, 0);
    chk("rst_wr_addr", wr_addr0, 0);
    chk("rst_wr_data", wr_data0, 0);
    chk("rst_count", fifo_count0, 0);
    chk("rst_ready", alu_ready0, 0);
    chk("rst_busy", busy_hit0, 0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", alu_ready0, 1);

    // Single bypassed ALU write
    alu_valid = 1'b1; alu_dr = 5'd3; alu_data = 32'hA5A5A5A5;
    #1;
    chk("busy_alu_req", busy_hit0, 1);
    tick();
    idle();
    chk("byp_wr_en", wr_en0, 1);
    chk("byp_wr_addr", wr_addr0, 3);
    chk("byp_wr_data", wr_data0, 32'hA5A5A5A5);
    chk("byp_count", fifo_count0, 0);
    tick();
    chk("byp_idle_wr_en", wr_en0, 0);

    // Mem and ALU conflict in the same cycle
    mem_valid = 1'b1; mem_dr = 5'd5; mem_data = 32'h11;
    alu_valid = 1'b1; alu_dr = 5'd6; alu_data = 32'h22;
    tick();
    idle();
    chk("cf1_wr_en", wr_en0, 1);
    chk("cf1_wr_addr", wr_addr0, 5);
    chk("cf1_wr_data", wr_data0, 32'h11);
    chk("cf1_count", fifo_count0, 1);
    query_addr = 5'd6;
    #1;
    chk("cf_busy_queued", busy_hit0, 1);
    tick();
    chk("cf2_wr_en", wr_en0, 1);
    chk("cf2_wr_addr", wr_addr0, 6);
    chk("cf2_wr_data", wr_data0, 32'h22);
    chk("cf2_count", fifo_count0, 0);

    // Backpressure: mem held for 6 cycles while the ALU streams
    for (int k = 0; k < 6; k++) begin
      mem_valid = 1'b1; mem_dr = 5'(10 + k); mem_data = 32'(k);
      alu_valid = 1'b1;
      alu_dr    = (k < 4) ? 5'(20 + k) : 5'd24;
      alu_data  = (k < 4) ? 32'(256 + k) : 32'hDEAD;
      #1;
      chk($sformatf("bp_ready_%0d", k), alu_ready0, (k < 4) ? 1 : 0);
      tick();
      chk($sformatf("bp_wr_addr_%0d", k), wr_addr0, 10 + k);
      chk($sformatf("bp_wr_data_%0d", k), wr_data0, k);
      chk($sformatf("bp_count_%0d", k), fifo_count0, (k < 3) ? k + 1 : 4);
    end
    idle();
    for (int j = 0; j < 4; j++) begin
      tick();
      chk($sformatf("dr_wr_en_%0d", j), wr_en0, 1);
      chk($sformatf("dr_wr_addr_%0d", j), wr_addr0, 20 + j);
      chk($sformatf("dr_wr_data_%0d", j), wr_data0, 256 + j);
      chk($sformatf("dr_count_%0d", j), fifo_count0, 3 - j);
    end
    tick();
    chk("dr_idle_wr_en", wr_en0, 0);

    // Kill: queued r7 is superseded by a later mem write to r7
    mem_valid = 1'b1; mem_dr = 5'd8; mem_data = 32'h55;
    alu_valid = 1'b1; alu_dr = 5'd7; alu_data = 32'h1;
    tick();
    chk("kl_wr_addr_r8", wr_addr0, 8);
    chk("kl_count_1", fifo_count0, 1);
    idle();
    mem_valid = 1'b1; mem_dr = 5'd7; mem_data = 32'h2;
    query_addr = 5'd7;
    #1;
    chk("kl_busy_pre", busy_hit0, 1);
    tick();
    idle();
    chk("kl_wr_en_mem", wr_en0, 1);
    chk("kl_wr_addr_mem", wr_addr0, 7);
    chk("kl_wr_data_mem", wr_data0, 32'h2);
    chk("kl_count_hold", fifo_count0, 1);
    chk("kl_busy_out", busy_hit0, 1);
    tick();
    chk("kl_pop_wr_en", wr_en0, 0);
    chk("kl_pop_count", fifo_count0, 0);
    chk("kl_busy_post", busy_hit0, 0);

    // Zero register
    alu_valid = 1'b1; alu_dr = 5'd0; alu_data = 32'h77;
    query_addr = 5'd0;
    #1;
    chk("z_ready", alu_ready0, 1);
    chk("z_busy_suppr", busy_hit0, 0);
    chk("z_busy_fwd", busy_hit1, 1);
    tick();
    idle();
    chk("z_wr_en_suppr", wr_en0, 0);
    chk("z_count", fifo_count0, 0);
    chk("z_wr_en_fwd", wr_en1, 1);
    chk("z_wr_addr_fwd", wr_addr1, 0);
    chk("z_wr_data_fwd", wr_data1, 32'h77);
    tick();

    // Async reset with three entries queued
    for (int k = 0; k < 3; k++) begin
      mem_valid = 1'b1; mem_dr = 5'(12 + k); mem_data = 32'(k);
      alu_valid = 1'b1; alu_dr = 5'(1 + k);  alu_data = 32'(100 + k);
      tick();
    end
    idle();
    chk("ar_count_3", fifo_count0, 3);
    chk("ar_wr_en_pre", wr_en0, 1);
    query_addr = 5'd1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_wr_en", wr_en0, 0);
    chk("ar_count", fifo_count0, 0);
    chk("ar_ready", alu_ready0, 0);
    chk("ar_busy", busy_hit0, 0);
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk($sformatf("ar_stale_wr_en_%0d", j), wr_en0, 0);
      chk($sformatf("ar_stale_count_%0d", j), fifo_count0, 0);
    end
    alu_valid = 1'b1; alu_dr = 5'd9; alu_data = 32'h99;
    tick();
    idle();
    chk("ar_fresh_wr_en", wr_en0, 1);
    chk("ar_fresh_wr_addr", wr_addr0, 9);
    chk("ar_fresh_wr_data", wr_data0, 32'h99);
    chk("ar_fresh_count", fifo_count0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
